mem_port_arbiter: RTL

// - Shares the single-port 64-bit Y86 data/instruction memory between the fetch stage (F port) and memory stage (M port).
// - Sits between the pipeline stages and the memory array; owns mem_en/mem_we/mem_addr/mem_wdata.
// - Memory-stage requests have priority; a starvation counter guarantees fetch progress.

---
 rtl/y86_mem_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/y86_mem_pkg.sv
// Shared constants and types for the Y86 memory-port arbiter.
package y86_mem_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_RESP
    } arb_state_t;

    typedef enum logic {
        PORT_F,
        PORT_M
    } port_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Request selection between fetch and memory stage, with a saturating
// starvation counter that forces a fetch grant after repeated M wins.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4,
    localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_en,
    input  logic f_req,
    input  logic m_req,
    output logic gnt_f,
    output logic gnt_m
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_f;

    // Memory stage wins unless fetch has been waiting through STARVE_MAX M grants.
    always_comb begin
        force_f = f_req && (starve_cnt == CNT_MAX);
        gnt_f   = grant_en && f_req && (force_f || !m_req);
        gnt_m   = grant_en && m_req && !force_f;
    end

    // Count M grants that overtook a waiting fetch; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!f_req || gnt_f) begin
            starve_cnt <= '0;
        end else if (gnt_m && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port Y86 memory between the fetch (F) and memory-stage (M)
// ports: M has priority, reads block the array for MEM_LAT+2 cycles, writes
// complete in the grant cycle, out-of-range addresses return an error pulse.
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [63:0]       m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int              LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [63:0]      DEPTH_64 = 64'(DEPTH);

    arb_state_t       state;
    arb_state_t       state_next;
    port_id_t         owner;
    logic [LAT_W-1:0] lat_cnt;
    logic             grant_en;
    logic             gnt_f;
    logic             gnt_m;
    logic             any_gnt;
    logic             sel_bad;
    logic             sel_we;
    logic             rd_start;
    logic             rd_done;
    logic [63:0]      sel_addr;

    assign grant_en = (state == IDLE);
    assign busy     = (state != IDLE);

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .grant_en(grant_en),
        .f_req   (f_req),
        .m_req   (m_req),
        .gnt_f   (gnt_f),
        .gnt_m   (gnt_m)
    );

    // Drive the memory straight from the granted request and decide the next FSM state.
    always_comb begin
        sel_addr   = gnt_f ? f_addr : m_addr;
        any_gnt    = gnt_f || gnt_m;
        sel_bad    = any_gnt && (sel_addr >= DEPTH_64);
        sel_we     = gnt_m && m_we;
        rd_start   = any_gnt && !sel_bad && !sel_we;
        rd_done    = (state == RD_WAIT) && (lat_cnt == '0);
        f_gnt      = gnt_f;
        m_gnt      = gnt_m;
        mem_en     = any_gnt && !sel_bad;
        mem_we     = mem_en && sel_we;
        mem_addr   = mem_en ? sel_addr[ADDR_W-1:0] : '0;
        mem_wdata  = mem_we ? m_wdata : '0;
        state_next = state;
        case (state)
            IDLE:    if (rd_start) state_next = RD_WAIT;
            RD_WAIT: if (lat_cnt == '0) state_next = RD_RESP;
            RD_RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the read owner at grant and count down the memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            owner   <= PORT_F;
        end else if (rd_start) begin
            lat_cnt <= LAT_LOAD;
            owner   <= gnt_f ? PORT_F : PORT_M;
        end else if ((state == RD_WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    // Per-port response registers: one-cycle rvalid pulses for read data and bad addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            f_rdata  <= '0;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            m_rdata  <= '0;
        end else begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            if (sel_bad) begin
                if (gnt_f) begin
                    f_rvalid <= 1'b1;
                    f_err    <= 1'b1;
                    f_rdata  <= '0;
                end else begin
                    m_rvalid <= 1'b1;
                    m_err    <= 1'b1;
                    m_rdata  <= '0;
                end
            end else if (rd_done) begin
                if (owner == PORT_F) begin
                    f_rvalid <= 1'b1;
                    f_rdata  <= mem_rdata;
                end else begin
                    m_rvalid <= 1'b1;
                    m_rdata  <= mem_rdata;
                end
            end
        end
    end

endmodule
